sevenseg_count_display: RTL and testbench
=========================================

# sevenseg_count_display

Drives the Basys3 4-digit, 7-segment display from a 16-bit count. It is the display stage placed directly downstream of the LED binary counter, consuming the same `binary_count` value that drives the LEDs. It accepts a value through a valid/ready handshake and can convert it to decimal with a sequential double-dabble engine. It time-multiplexes the four digits with a free-running refresh counter.

## Interface
- `REFRESH_BITS`, default 18: refresh counter width. Frame = 2^REFRESH_BITS cycles; each digit is lit for 2^(REFRESH_BITS-2) cycles (655 µs at 100 MHz).
- `DECIMAL`, default 0: 0 = hex display, 1 = decimal (BCD) display.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `value` in 16: count to display.
- `value_valid` in 1: `value` is offered.
- `value_ready` out 1: block can accept `value`.
- `blank_lz` in 1: enables leading-zero blanking.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low; held at 1.
- `an` out 4: digit anodes, active-low; `an[0]` is the rightmost digit.

## Operation
- Control FSM has three states: IDLE, CONV, DONE.
  - `value_ready` = 1 only in IDLE and not in reset.
  - In IDLE, `value_valid & value_ready` captures `value`.
    - DECIMAL=0: go to DONE.
    - DECIMAL=1: go to CONV with a 16-cycle shift counter.
  - CONV performs double-dabble: each cycle, add 3 to every BCD nibble ≥5, then shift left one bit. The BCD accumulator is 20 bits (5 digits). After 16 cycles, go to DONE.
  - DONE commits four display digits atomically, then returns to IDLE.
  - `value_valid` while `value_ready`=0 is ignored; no capture and no queuing.
- Decimal overflow: if BCD digit 4 ≠ 0 (value > 9999), all four digits show a dash (`seg`=0111111).
- Hex mode: digit i = `value[4i+3:4i]`.
- Segment codes, 0–F:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - A: 0001000
  - b: 0000011
  - C: 1000110
  - d: 0100001
  - E: 0000110
  - F: 0001110
- Scan:
  - The refresh counter increments every cycle and wraps at 2^REFRESH_BITS.
  - Digit index = top 2 bits of the counter.
  - The selected digit's `an` bit is 0; all others are 1.
- Leading-zero blanking, when `blank_lz`=1:
  - Digit i (i=3..1) is blanked if digits 3 down to i are all zero.
  - Digit 0 is never blanked.
  - In a blanked slot, `an`=1111 and `seg`=1111111.
  - Dashes are never blanked.
- Reset, at any state including mid-CONV:
  - FSM goes to IDLE, the refresh counter to 0, and all display digits to 0.
  - Any conversion in progress is discarded.

## Timing
- Reset values, during `rst` and at the first edge after: `an`=1111, `seg`=1111111, `dp`=1, `value_ready`=0.
- `value_ready`=1 from the first cycle after `rst` deasserts.
- `an` and `seg` are registered. They reflect the refresh counter index with 1-cycle latency.
- After reset, the first lit slot is digit 0 showing '0'.
- Handshake accepted at edge N:
  - Hex: digits are updated at edge N+1, and `value_ready` is high again after edge N+1. `value_ready` is low for 1 cycle.
  - Decimal: CONV occupies edges N+1..N+16, DONE commits at edge N+17, and `value_ready` is high after N+17. `value_ready` is low for 17 cycles.
- Display change takes effect at the next scan slot. There are no partial updates and no tearing.
- The refresh counter is independent of the handshake and never stalls.

## Structure
- Package `sevenseg_pkg`:
  - FSM state enum {IDLE, CONV, DONE}.
  - Constants `SEG_BLANK`=7'b1111111 and `SEG_DASH`=7'b0111111.
  - Function `hex_to_seg(4-bit) -> 7-bit`.
- Sub-module `bin16_to_bcd`:
  - Sequential double-dabble engine with `start`, `busy`, `done`, 16-bit input and 20-bit BCD output.
  - The top level owns the handshake, the commit, the scan and the blanking.

## Test plan
Simulate with REFRESH_BITS=4, so each slot lasts 4 cycles.
- Reset: hold `rst` for 3 cycles → `an`=1111, `seg`=1111111, `dp`=1, `value_ready`=0. One cycle after release, `value_ready`=1.
- Hex: DECIMAL=0, `value`=16'hBEEF, `value_valid` for 1 cycle → `value_ready` low exactly 1 cycle. Scan shows:
  - `an`=1110 with `seg`=0001110 (F)
  - `an`=1101 with 0000110 (E)
  - `an`=1011 with 0000110 (E)
  - `an`=0111 with 0000011 (b)
- Decimal: DECIMAL=1, `value`=1234 → `value_ready` low exactly 17 cycles. Digits 4,3,2,1 appear on an0..an3. A second `value_valid` pulse during CONV is ignored and the display still shows 1234.
- Overflow: `value`=10000 → all slots show `seg`=0111111. `value`=9999 → all slots show 0010000.
- Blanking: `blank_lz`=1, hex, `value`=16'h0005 → slot 0 shows `an`=1110 with 0010010; slots 1–3 show `an`=1111. `value`=0 → only slot 0 is lit, showing '0'.
- Reset mid-CONV: DECIMAL=1, display showing 42. Send `value`=1234, then assert `rst` on CONV cycle 8 → display shows '0' in all digits (or digit 0 only with `blank_lz`). `value_ready`=1 one cycle after release, and 1234 never appears.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared FSM states, segment constants and the hex-to-segment font.
package sevenseg_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam int BIN_W = 16;
  localparam int BCD_W = 20;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  // Segments {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction
endpackage

// File: rtl/sevenseg_if.sv
// sevenseg_if: valid/ready channel carrying the count into the display block.
interface sevenseg_if;
  logic [15:0] value;
  logic value_valid;
  logic value_ready;
  modport master(output value, value_valid, input value_ready);
  modport slave(input value, value_valid, output value_ready);
endinterface

// File: rtl/bin16_to_bcd.sv
// bin16_to_bcd: sequential double-dabble, one shift per cycle for 16 cycles after start.
module bin16_to_bcd
  import sevenseg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);
  logic [BIN_W-1:0] sh_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [4:0] cnt_q;
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < BCD_W / 4; k++)
      adj[4*k+:4] = bcd_q[4*k+:4] >= 4'd5 ? bcd_q[4*k+:4] + 4'd3 : bcd_q[4*k+:4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      sh_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= 5'd16;
    end else if (busy_o) begin
      {bcd_q, sh_q} <= {adj, sh_q} << 1;
      cnt_q <= cnt_q - 5'd1;
    end
  end
  // done_o marks the cycle whose edge performs the final shift.
  assign busy_o = cnt_q != 5'd0;
  assign done_o = cnt_q == 5'd1;
  assign bcd_o = bcd_q;
endmodule

// File: rtl/sevenseg_count_display.sv
// sevenseg_count_display: handshake capture, optional BCD conversion, atomic digit commit
// and multiplexed 4-digit scan with leading-zero blanking.
module sevenseg_count_display
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter bit DECIMAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  sevenseg_if.slave        vif,
  input  logic             blank_lz,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an
);
  state_t state_q;
  logic ready_q;
  logic [15:0] val_q;
  logic [3:0][3:0] dig_q;
  logic ovf_q;
  logic [REFRESH_BITS-1:0] ref_q;
  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic accept;
  logic eng_busy;
  logic eng_done;
  logic [BCD_W-1:0] bcd;
  logic [1:0] idx;
  logic [3:0] cur;
  logic blank;
  assign accept = state_q == IDLE && ready_q && vif.value_valid;
  bin16_to_bcd u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && DECIMAL),
    .bin_i   (vif.value),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .bcd_o   (bcd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      val_q <= '0;
      dig_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= !accept;
          if (accept) begin
            val_q <= vif.value;
            state_q <= DECIMAL ? CONV : DONE;
          end
        end
        CONV: if (eng_done || !eng_busy) state_q <= DONE;
        DONE: begin
          // All four digits change in one edge so the scan never shows a mixed value.
          dig_q <= DECIMAL ? bcd[15:0] : val_q;
          ovf_q <= DECIMAL && bcd[19:16] != 4'd0;
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign idx = ref_q[REFRESH_BITS-1-:2];
  assign cur = dig_q[idx];
  assign blank = blank_lz && !ovf_q && idx != 2'd0 &&
                 (idx == 2'd3 ? dig_q[3] == 4'd0 :
                  idx == 2'd2 ? dig_q[3:2] == 8'd0 : dig_q[3:1] == 12'd0);
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      an_q <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      ref_q <= ref_q + 1'b1;
      an_q <= blank ? 4'b1111 : ~(4'b0001 << idx);
      seg_q <= blank ? SEG_BLANK : ovf_q ? SEG_DASH : hex_to_seg(cur);
    end
  end
  assign vif.value_ready = ready_q;
  assign seg = seg_q;
  assign an = an_q;
  assign dp = 1'b1;
endmodule

// File: tb/tb_sevenseg_count_display.sv
// tb_sevenseg_count_display: hex and decimal instances checked frame-by-frame against an arithmetic model.
module tb_sevenseg_count_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic blz = 1'b0;
  logic [6:0] seg_h, seg_d;
  logic dp_h, dp_d;
  logic [3:0] an_h, an_d;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int shown[2];
  logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  sevenseg_if hif ();
  sevenseg_if dif ();
  sevenseg_count_display #(.REFRESH_BITS(4), .DECIMAL(1'b0)) u_hex (
    .clk(clk), .rst(rst), .vif(hif), .blank_lz(blz), .seg(seg_h), .dp(dp_h), .an(an_h));
  sevenseg_count_display #(.REFRESH_BITS(4), .DECIMAL(1'b1)) u_dec (
    .clk(clk), .rst(rst), .vif(dif), .blank_lz(blz), .seg(seg_d), .dp(dp_d), .an(an_d));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(int d);
    return d != 0 ? dif.value_ready : hif.value_ready;
  endfunction

  task automatic drive(int d, logic valid, int v);
    if (d != 0) begin
      dif.value_valid = valid;
      dif.value = 16'(v);
    end else begin
      hif.value_valid = valid;
      hif.value = 16'(v);
    end
  endtask

  // Digit i of v in the instance's radix, and the part of v above digit i.
  function automatic int digit(int d, int v, int i);
    return d != 0 ? (v / (10 ** i)) % 10 : (v >> (4 * i)) & 15;
  endfunction

  function automatic int upper(int d, int v, int i);
    return d != 0 ? v / (10 ** i) : v >> (4 * i);
  endfunction

  task automatic check_frame(int d, string tag);
    int v, s;
    logic dash, bl;
    logic [3:0] ea;
    logic [6:0] es;
    v = shown[d];
    step();
    repeat (16) begin
      step();
      s = ((cyc - 1) % 16) / 4;
      dash = d != 0 && v > 9999;
      bl = blz && !dash && s > 0 && upper(d, v, s) == 0;
      ea = bl ? 4'b1111 : 4'(~(1 << s));
      es = dash ? 7'b0111111 : bl ? 7'b1111111 : font[digit(d, v, s)];
      check({tag, "/an"}, d != 0 ? an_d : an_h, ea);
      check({tag, "/seg"}, d != 0 ? seg_d : seg_h, es);
    end
  endtask

  task automatic send(int d, int v, string tag);
    int k, low;
    k = 0;
    while (!rdy(d) && k < 50) begin
      step();
      k++;
    end
    check({tag, "/ready_wait"}, rdy(d), 1);
    drive(d, 1'b1, v);
    step();
    drive(d, 1'b0, v);
    low = 0;
    while (!rdy(d) && low < 100) begin
      if (low == 5) drive(d, 1'b1, 5678);
      if (low == 6) drive(d, 1'b0, 0);
      step();
      low++;
    end
    drive(d, 1'b0, 0);
    check({tag, "/ready_low"}, low, d != 0 ? 17 : 1);
    shown[d] = v;
    check_frame(d, tag);
  endtask

  initial begin
    int d, v;
    shown[0] = 0;
    shown[1] = 0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    repeat (3) step();
    check("rst/an_h", an_h, 4'b1111);
    check("rst/seg_h", seg_h, 7'b1111111);
    check("rst/dp_h", dp_h, 1);
    check("rst/rdy_h", hif.value_ready, 0);
    check("rst/an_d", an_d, 4'b1111);
    check("rst/seg_d", seg_d, 7'b1111111);
    check("rst/dp_d", dp_d, 1);
    check("rst/rdy_d", dif.value_ready, 0);
    rst = 1'b0;
    step();
    check("rel/rdy_h", hif.value_ready, 1);
    check("rel/rdy_d", dif.value_ready, 1);
    check_frame(0, "zero_h");
    check_frame(1, "zero_d");
    send(0, 16'hBEEF, "beef");
    send(1, 1234, "dec1234");
    send(1, 10000, "ovf10000");
    send(1, 9999, "dec9999");
    blz = 1'b1;
    send(0, 5, "blz_5");
    send(0, 0, "blz_0");
    send(1, 70, "blz_d70");
    send(1, 10000, "blz_dash");
    repeat (24) begin
      blz = 1'($urandom_range(0, 1));
      d = int'($urandom_range(0, 1));
      v = d != 0 ? int'($urandom_range(0, 12000)) : int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) v = v % 100;
      send(d, v, d != 0 ? "rnd_d" : "rnd_h");
    end
    blz = 1'b0;
    send(1, 42, "dec42");
    drive(1, 1'b1, 1234);
    step();
    drive(1, 1'b0, 0);
    repeat (7) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("midrst/rdy_d", dif.value_ready, 1);
    check("midrst/rdy_h", hif.value_ready, 1);
    shown[0] = 0;
    shown[1] = 0;
    check_frame(1, "midrst_d");
    blz = 1'b1;
    check_frame(1, "midrst_dblz");
    check_frame(0, "midrst_h");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
